// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter with a one-entry hold register for back-to-back frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data bit 7 and the stop bits.
module uart_tx #(
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       otx,
  output logic       busy
);
  localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic r_par;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t        r_state, w_state;
  logic [7:0]    r_hold, r_shift, w_shift;
  logic          r_hold_valid, r_otx, w_otx, r_stop_cnt, w_stop_cnt;
  logic          w_load, w_accept, w_bit_done;
  logic [2:0]    r_bit_cnt, w_bit_cnt;
  logic [BW-1:0] r_baud, w_baud;
  assign w_bit_done = r_baud == BW'(CLKS_PER_BIT - 1);
  assign w_accept   = tx_valid && !r_hold_valid;
  assign tx_ready   = !r_hold_valid;
  assign otx        = r_otx;
  assign busy       = (r_state != IDLE) || r_hold_valid;
  always_comb begin
    w_state    = r_state;
    w_otx      = r_otx;
    w_shift    = r_shift;
    w_bit_cnt  = r_bit_cnt;
    w_stop_cnt = r_stop_cnt;
    w_load     = 1'b0;
    w_baud     = w_bit_done ? '0 : r_baud + 1'b1;
    case (r_state)
      IDLE: begin
        w_baud = '0;
        w_otx  = 1'b1;
        if (r_hold_valid) begin
          w_state = START;
          w_load  = 1'b1;
          w_shift = r_hold;
          w_otx   = 1'b0;
        end
      end
      START: if (w_bit_done) begin
        w_state   = DATA;
        w_otx     = r_shift[0];
        w_bit_cnt = 3'd0;
      end
      DATA: if (w_bit_done) begin
        w_shift   = r_shift >> 1;
        w_bit_cnt = r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          w_state    = PARITY;
          w_otx      = r_par;
`else
          w_state    = STOP;
          w_otx      = 1'b1;
          w_stop_cnt = 1'b0;
`endif
        end else begin
          w_otx = r_shift[1];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (w_bit_done) begin
        w_state    = STOP;
        w_otx      = 1'b1;
        w_stop_cnt = 1'b0;
      end
`endif
      STOP: if (w_bit_done) begin
        if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
          // A queued byte starts immediately so frames run without an idle gap.
          w_state = r_hold_valid ? START : IDLE;
          w_load  = r_hold_valid;
          w_shift = r_hold_valid ? r_hold : r_shift;
          w_otx   = !r_hold_valid;
        end else begin
          w_stop_cnt = 1'b1;
        end
      end
      default: begin
        w_state = IDLE;
        w_otx   = 1'b1;
        w_baud  = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_otx        <= 1'b1;
      r_hold_valid <= 1'b0;
      r_hold       <= '0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_stop_cnt   <= 1'b0;
      r_baud       <= '0;
`ifdef UART_TX_PARITY_EN
      r_par        <= 1'b0;
`endif
    end else begin
      r_state      <= w_state;
      r_otx        <= w_otx;
      r_hold_valid <= w_accept || (r_hold_valid && !w_load);
      r_shift      <= w_shift;
      r_bit_cnt    <= w_bit_cnt;
      r_stop_cnt   <= w_stop_cnt;
      r_baud       <= w_baud;
      if (w_accept) r_hold <= tx_data;
`ifdef UART_TX_PARITY_EN
      if (w_load) r_par <= ^r_hold;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench; each accepted byte queues its expected per-cycle otx waveform,
// and a line monitor per instance captures each frame from its start bit and compares it.
module tb_uart_tx;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int L1 = 10 + P;
  localparam int L4 = (11 + P) * 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] d1 = '0, d4 = '0;
  logic v1 = 1'b0, v4 = 1'b0;
  logic rdy1, otx1, busy1, rdy4, otx4, busy4;
  int cyc = 0, pass = 0, total = 0, acc = 0, rise = 0, nacc = 0;
  logic [63:0] q1[$], q4[$];
  int starts1[$];
  logic [63:0] obs1, obs4;
  logic ok1, ok4, w;

  uart_tx #(.CLKS_PER_BIT(1), .STOP_BITS(1)) u1 (
    .clk(clk), .reset(reset), .tx_data(d1), .tx_valid(v1),
    .tx_ready(rdy1), .otx(otx1), .busy(busy1));
  uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u4 (
    .clk(clk), .reset(reset), .tx_data(d4), .tx_valid(v4),
    .tx_ready(rdy4), .otx(otx4), .busy(busy4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] exp_frame(input logic [7:0] d, input int c, input int stops);
    logic [63:0] v = '1;
    logic [11:0] b = '1;
    int n = 9, k = 0;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[i+1] = d[i];
    if (P == 1) begin b[n] = ^d; n++; end
    for (int s = 0; s < stops; s++) begin b[n] = 1'b1; n++; end
    for (int i = 0; i < n; i++)
      for (int j = 0; j < c; j++) begin v[k] = b[i]; k++; end
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic fail(input string nm);
    total++;
    $display("FAIL %s: got no completion, required completion", nm);
  endtask

  task automatic send(input bit u, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    if (u) begin v4 = 1'b1; d4 = d; end else begin v1 = 1'b1; d1 = d; end
    while (!(u ? rdy4 : rdy1) && n < 200) begin @(negedge clk); n++; end
    if (!(u ? rdy4 : rdy1)) begin fail("send timeout"); v1 = 1'b0; v4 = 1'b0; return; end
    @(posedge clk);
    #1;
    acc = cyc;
    if (u) q4.push_back(exp_frame(d, 4, 2)); else q1.push_back(exp_frame(d, 1, 1));
    v1 = 1'b0;
    v4 = 1'b0;
  endtask

  initial forever begin
    @(negedge clk);
    if (reset && otx1 == 1'b0) begin
      starts1.push_back(cyc);
      obs1 = '1;
      obs1[0] = otx1;
      ok1 = 1'b1;
      for (int i = 1; i < L1; i++) begin
        @(negedge clk);
        if (!reset) begin ok1 = 1'b0; break; end
        obs1[i] = otx1;
      end
      if (ok1) begin
        if (q1.size() == 0) fail("u1 unexpected frame");
        else chk("u1 frame", obs1, q1.pop_front());
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (reset && otx4 == 1'b0) begin
      obs4 = '1;
      obs4[0] = otx4;
      ok4 = 1'b1;
      for (int i = 1; i < L4; i++) begin
        @(negedge clk);
        if (!reset) begin ok4 = 1'b0; break; end
        obs4[i] = otx4;
      end
      if (ok4) begin
        if (q4.size() == 0) fail("u4 unexpected frame");
        else chk("u4 frame", obs4, q4.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  initial begin
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst otx1", otx1, 1);
    chk("rst rdy1", rdy1, 1);
    chk("rst busy1", busy1, 0);
    chk("rst otx4", otx4, 1);
    chk("rst rdy4", rdy4, 1);
    chk("rst busy4", busy4, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    // single frame 0xA5: start latency and idle afterwards
    starts1.delete();
    send(0, 8'hA5);
    repeat (L1 + 4) @(negedge clk);
    chk("latency", starts1.size() > 0 ? starts1[0] : -1, acc + 1);
    chk("busy after", busy1, 0);
    chk("otx idle", otx1, 1);
    // back-to-back 0x00 then 0xFF
    starts1.delete();
    send(0, 8'h00);
    send(0, 8'hFF);
    chk("rdy after 2nd accept", rdy1, 0);
    begin
      int n = 0;
      @(negedge clk);
      while (!rdy1 && n < 100) begin @(negedge clk); n++; end
      rise = cyc;
    end
    repeat (L1 + 4) @(negedge clk);
    chk("b2b gap", starts1.size() >= 2 ? starts1[1] - starts1[0] : -1, L1);
    chk("rdy rise at start2", starts1.size() >= 2 ? starts1[1] : -1, rise);
    // valid held high with changing data; only bytes at accept edges are sent
    @(negedge clk);
    v1 = 1'b1;
    nacc = 0;
    for (int k = 0; k < 14; k++) begin
      d1 = 8'h30 + 8'(k * 7);
      w = rdy1;
      @(posedge clk);
      if (w) begin q1.push_back(exp_frame(d1, 1, 1)); nacc++; end
      @(negedge clk);
    end
    v1 = 1'b0;
    chk("accept count", nacc, 3);
    repeat (3 * L1 + 10) @(negedge clk);
    // parity pair 0x07, 0x03
    send(0, 8'h07);
    send(0, 8'h03);
    repeat (2 * L1 + 6) @(negedge clk);
    // slow instance: 4 clocks per bit, 2 stop bits
    send(1, 8'h01);
    repeat (L4 + 8) @(negedge clk);
    chk("u4 busy after", busy4, 0);
    // reset mid-DATA with a byte held
    send(0, 8'h3C);
    send(0, 8'hC3);
    repeat (2) @(negedge clk);
    chk("held before rst", rdy1, 0);
    #2 reset = 1'b0;
    #1;
    chk("mid rst otx", otx1, 1);
    chk("mid rst rdy", rdy1, 1);
    chk("mid rst busy", busy1, 0);
    q1.delete();
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    send(0, 8'h5A);
    repeat (2 * L1 + 10) @(negedge clk);
    chk("q1 drained", q1.size(), 0);
    chk("q4 drained", q4.size(), 0);
    chk("final busy", busy1, 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
